// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tdm_pkg
// Purpose : Shared definitions for the two-channel TDM link (TX mux and RX
//           demux sides): frame-tracking state codes, slot-kind codes and
//           default word / counter widths.
// Revision: 1.0 - initial release
// ============================================================================
package tdm_pkg;

    // Default geometry, shared with the TX mux side
    localparam int c_WIDTH_DEF = 8;
    localparam int c_CNT_W_DEF = 8;

    // Slot kinds within a frame
    localparam logic c_SLOT_A = 1'b0;
    localparam logic c_SLOT_B = 1'b1;

    // Receive frame-tracking state codes
    typedef logic [1:0] state_t;
    localparam state_t c_ST_HUNT  = 2'd0;  // no frame lock, waiting for Sof
    localparam state_t c_ST_EXP_A = 2'd1;  // next slot must be an A slot (Sof)
    localparam state_t c_ST_EXP_B = 2'd2;  // next slot must be a B slot

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_chan_reg.sv
`default_nettype none
// ============================================================================
// Module  : tdm_chan_reg
// Purpose : One-deep valid/ready output register for one demuxed channel.
//           A pushed word is captured when the register is empty or is being
//           drained in the same cycle; otherwise it is dropped and o_ovf
//           flags the drop combinationally in that same cycle.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_push/i_data - new word offered this cycle
//           o_data/o_vld  - held word and its valid flag
//           i_rdy         - consumer takes the word when o_vld & i_rdy
//           o_ovf         - push refused because the held word is stuck
// Revision: 1.0 - initial release
// ============================================================================
module tdm_chan_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld,
    output logic             o_ovf
);

    logic [WIDTH-1:0] r_data;
    logic             r_vld;
    logic             w_accept;

    // Accept into an empty slot, or refill while the held word drains.
    assign w_accept = i_push & (~r_vld | i_rdy);
    assign o_ovf    = i_push & r_vld & ~i_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else if (w_accept) begin
            r_data <= i_data;
            r_vld  <= 1'b1;
        end else if (r_vld & i_rdy) begin
            r_vld  <= 1'b0;   // data left as-is after consumption
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;

endmodule : tdm_chan_reg
`default_nettype wire

// File: rtl/tdm_demux2_1.sv
`default_nettype none
// ============================================================================
// Module  : tdm_demux2_1
// Purpose : Two-channel TDM receive demultiplexer. Splits a shared A/B slot
//           stream (Sof marks the A slot) into two independently handshaked
//           one-deep channel outputs, flagging misalignment and overflow on a
//           registered one-cycle Err pulse.
// Ports   : CLK, RST            - clock, synchronous active-high reset
//           Y, Yvld, Sof        - shared link word, valid, start-of-frame
//           A, Avld, Ardy       - channel A output handshake
//           B, Bvld, Brdy       - channel B output handshake
//           Err                 - misalignment / overflow pulse
//           FrameCnt, DropCnt   - saturating statistics
// Config  : TDM_DEMUX_STATS_EN  - when defined, FrameCnt/DropCnt are live
//                                 counters; otherwise they are tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
module tdm_demux2_1
    import tdm_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int CNT_W = c_CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Y,
    input  logic             Yvld,
    input  logic             Sof,
    output logic [WIDTH-1:0] A,
    output logic             Avld,
    input  logic             Ardy,
    output logic [WIDTH-1:0] B,
    output logic             Bvld,
    input  logic             Brdy,
    output logic             Err,
    output logic [CNT_W-1:0] FrameCnt,
    output logic [CNT_W-1:0] DropCnt
);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_push_a;
    logic   w_push_b;
    logic   w_misalign;
    logic   w_ovf_a;
    logic   w_ovf_b;
    logic   r_err;

    // ------------------------------------------------------------------
    // Frame tracking
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push_a    = 1'b0;
        w_push_b    = 1'b0;
        w_misalign  = 1'b0;
        if (Yvld) begin
            case (r_state)
                c_ST_HUNT: begin
                    // Non-Sof words while unlocked are discarded silently.
                    if (Sof) begin
                        w_push_a    = 1'b1;
                        w_state_nxt = c_ST_EXP_B;
                    end
                end
                c_ST_EXP_B: begin
                    if (!Sof) begin
                        w_push_b    = 1'b1;
                        w_state_nxt = c_ST_EXP_A;
                    end else begin
                        // Premature Sof: treat it as the A slot of a new frame.
                        w_misalign  = 1'b1;
                        w_push_a    = 1'b1;
                    end
                end
                c_ST_EXP_A: begin
                    if (Sof) begin
                        w_push_a    = 1'b1;
                        w_state_nxt = c_ST_EXP_B;
                    end else begin
                        // Missing Sof: lock is lost, word cannot be placed.
                        w_misalign  = 1'b1;
                        w_state_nxt = c_ST_HUNT;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Channel output registers
    // ------------------------------------------------------------------
    tdm_chan_reg #(.WIDTH(WIDTH)) u_chan_a (
        .clk    (CLK),
        .rst    (RST),
        .i_push (w_push_a),
        .i_data (Y),
        .i_rdy  (Ardy),
        .o_data (A),
        .o_vld  (Avld),
        .o_ovf  (w_ovf_a)
    );

    tdm_chan_reg #(.WIDTH(WIDTH)) u_chan_b (
        .clk    (CLK),
        .rst    (RST),
        .i_push (w_push_b),
        .i_data (Y),
        .i_rdy  (Brdy),
        .o_data (B),
        .o_vld  (Bvld),
        .o_ovf  (w_ovf_b)
    );

    // Coincident misalignment and overflow merge into a single pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_misalign | w_ovf_a | w_ovf_b;
        end
    end

    assign Err = r_err;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef TDM_DEMUX_STATS_EN
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_frame_done;
    logic             w_drop;

    // A frame completes when its B slot is taken, even if B overflows.
    assign w_frame_done = w_push_b;
    // Only one channel is pushed per cycle, so at most one drop per cycle.
    assign w_drop       = w_ovf_a | w_ovf_b;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_frame_done && (r_frame_cnt != '1)) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign FrameCnt = r_frame_cnt;
    assign DropCnt  = r_drop_cnt;
`else
    assign FrameCnt = '0;
    assign DropCnt  = '0;
`endif

endmodule : tdm_demux2_1
`default_nettype wire

// File: tb/tb_tdm_demux2_1.sv
`default_nettype none
// ============================================================================
// Module  : tb_tdm_demux2_1
// Purpose : Self-checking bench for tdm_demux2_1. A behavioural model of the
//           slot-routing rules predicts every output each cycle; directed
//           literal checks pin the model at key points.
// Config  : TDM_DEMUX_STATS_EN selects expected counter behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tdm_demux2_1;

`ifdef TDM_DEMUX_STATS_EN
    localparam int c_STATS = 1;
`else
    localparam int c_STATS = 0;
`endif
    localparam int c_SAT = 255;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] Y = '0;
    logic       Yvld = 1'b0;
    logic       Sof = 1'b0;
    logic [7:0] A;
    logic       Avld;
    logic       Ardy = 1'b1;
    logic [7:0] B;
    logic       Bvld;
    logic       Brdy = 1'b1;
    logic       Err;
    logic [7:0] FrameCnt;
    logic [7:0] DropCnt;

    int n_checks = 0;
    int n_errors = 0;

    tdm_demux2_1 #(.WIDTH(8), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .Y(Y), .Yvld(Yvld), .Sof(Sof),
        .A(A), .Avld(Avld), .Ardy(Ardy),
        .B(B), .Bvld(Bvld), .Brdy(Brdy),
        .Err(Err), .FrameCnt(FrameCnt), .DropCnt(DropCnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: frame position is "unlocked", "want A" or "want B";
    // each channel is a one-word holding slot.
    // ------------------------------------------------------------------
    int         m_pos;         // 0 unlocked, 1 next word should be A, 2 next should be B
    logic [7:0] m_data [2];
    bit         m_vld  [2];
    bit         m_err;
    int         m_frames;
    int         m_drops;
    bit         m_live = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            m_pos = 0; m_data[0] = 0; m_data[1] = 0; m_vld[0] = 0; m_vld[1] = 0;
            m_err = 0; m_frames = 0; m_drops = 0; m_live = 1'b1;
        end else begin
            int  route;
            bit  rdy [2];
            route = -1;
            m_err = 0;
            rdy[0] = Ardy;
            rdy[1] = Brdy;
            if (Yvld) begin
                if (m_pos == 0) begin
                    if (Sof) begin route = 0; m_pos = 2; end
                end else if (m_pos == 2) begin
                    if (!Sof) begin route = 1; m_frames++; m_pos = 1; end
                    else begin m_err = 1; route = 0; end
                end else begin
                    if (Sof) begin route = 0; m_pos = 2; end
                    else begin m_err = 1; m_pos = 0; end
                end
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (route == ch) begin
                    if (!m_vld[ch] || rdy[ch]) begin
                        m_data[ch] = Y;
                        m_vld[ch]  = 1;
                    end else begin
                        m_err = 1;
                        m_drops++;
                    end
                end else if (m_vld[ch] && rdy[ch]) begin
                    m_vld[ch] = 0;
                end
            end
        end
    end

    function automatic int sat(input int v);
        return (v > c_SAT) ? c_SAT : v;
    endfunction

    always @(negedge CLK) begin
        if (m_live) begin
            chk("cyc_A",    {24'd0, A},    {24'd0, m_data[0]});
            chk("cyc_Avld", {31'd0, Avld}, {31'd0, m_vld[0]});
            chk("cyc_B",    {24'd0, B},    {24'd0, m_data[1]});
            chk("cyc_Bvld", {31'd0, Bvld}, {31'd0, m_vld[1]});
            chk("cyc_Err",  {31'd0, Err},  {31'd0, m_err});
            chk("cyc_FrameCnt", {24'd0, FrameCnt}, c_STATS * sat(m_frames));
            chk("cyc_DropCnt",  {24'd0, DropCnt},  c_STATS * sat(m_drops));
        end
    end

    int err_pulses = 0;
    always @(negedge CLK) if (Err === 1'b1) err_pulses++;

    // Apply one cycle of link input; returns 1 time unit after the edge.
    task automatic step(input logic v, input logic s, input logic [7:0] y);
        Yvld = v; Sof = s; Y = y;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(0, 0, 8'h00);
        RST = 1'b0;
    endtask

    initial begin
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        RST = 1'b0;
        chk("rst_Avld", {31'd0, Avld}, 0);
        chk("rst_Bvld", {31'd0, Bvld}, 0);
        chk("rst_A",    {24'd0, A}, 0);
        chk("rst_Err",  {31'd0, Err}, 0);
        chk("rst_FrameCnt", {24'd0, FrameCnt}, 0);

        // 1: basic frame
        Ardy = 1; Brdy = 1;
        step(1, 1, 8'h11);
        chk("t1_A", {24'd0, A}, 32'h11);
        chk("t1_Avld", {31'd0, Avld}, 1);
        step(1, 0, 8'h22);
        chk("t1_B", {24'd0, B}, 32'h22);
        chk("t1_Bvld", {31'd0, Bvld}, 1);
        chk("t1_Err", {31'd0, Err}, 0);
        chk("t1_FrameCnt", {24'd0, FrameCnt}, c_STATS);
        step(0, 0, 8'h00);

        // 2: hunting discards non-Sof words silently
        do_reset();
        step(1, 0, 8'h05);
        step(1, 0, 8'h06);
        chk("t2_Avld", {31'd0, Avld}, 0);
        chk("t2_Bvld", {31'd0, Bvld}, 0);
        chk("t2_Err",  {31'd0, Err}, 0);
        step(1, 1, 8'h07);
        chk("t2_A", {24'd0, A}, 32'h07);

        // 3: double Sof, consumer ready
        do_reset();
        step(1, 1, 8'h10);
        step(1, 1, 8'h20);
        chk("t3_Err", {31'd0, Err}, 1);
        chk("t3_A", {24'd0, A}, 32'h20);
        step(0, 0, 8'h00);
        chk("t3_Err_once", {31'd0, Err}, 0);
        // 3b: double Sof, consumer stalled
        do_reset();
        Ardy = 0;
        step(1, 1, 8'h10);
        step(1, 1, 8'h20);
        chk("t3b_Err", {31'd0, Err}, 1);
        chk("t3b_A", {24'd0, A}, 32'h10);
        chk("t3b_DropCnt", {24'd0, DropCnt}, c_STATS);
        step(1, 0, 8'h21);   // still in EXP_B: B slot accepted
        chk("t3b_B", {24'd0, B}, 32'h21);

        // 4: B stalled over three frames
        do_reset();
        Ardy = 1; Brdy = 0;
        err_pulses = 0;
        for (int f = 0; f < 3; f++) begin
            step(1, 1, 8'hA1 + 8'(f));
            chk("t4_A", {24'd0, A}, 32'hA1 + f);
            step(1, 0, 8'h31 + 8'(f));
        end
        step(0, 0, 8'h00);
        chk("t4_B", {24'd0, B}, 32'h31);
        chk("t4_err_pulses", err_pulses, 2);
        chk("t4_DropCnt", {24'd0, DropCnt}, 2 * c_STATS);
        chk("t4_FrameCnt", {24'd0, FrameCnt}, 3 * c_STATS);

        // 5: missing Sof in EXP_A drops lock
        do_reset();
        Ardy = 1; Brdy = 1;
        step(1, 1, 8'h41);
        step(1, 0, 8'h42);
        step(1, 0, 8'h44);
        chk("t5_Err", {31'd0, Err}, 1);
        chk("t5_Avld", {31'd0, Avld}, 0);
        step(1, 0, 8'h45);
        chk("t5_Err_silent", {31'd0, Err}, 0);
        chk("t5_Avld_silent", {31'd0, Avld}, 0);
        step(1, 1, 8'h46);
        chk("t5_A", {24'd0, A}, 32'h46);

        // 6: reset mid-frame
        Ardy = 0;
        step(1, 0, 8'h47);   // completes frame, now EXP_A
        step(1, 1, 8'h61);   // A stuck holding 0x46 -> overflow
        chk("t6_Avld_pre", {31'd0, Avld}, 1);
        RST = 1'b1;
        step(0, 0, 8'h00);
        RST = 1'b0;
        chk("t6_Avld", {31'd0, Avld}, 0);
        chk("t6_Bvld", {31'd0, Bvld}, 0);
        chk("t6_FrameCnt", {24'd0, FrameCnt}, 0);
        chk("t6_DropCnt", {24'd0, DropCnt}, 0);
        step(1, 0, 8'h62);   // HUNT: silently discarded
        chk("t6_Bvld_hunt", {31'd0, Bvld}, 0);
        chk("t6_Err_hunt", {31'd0, Err}, 0);

        // 7: frame counter saturation
        Ardy = 1; Brdy = 1;
        for (int f = 0; f < 260; f++) begin
            step(1, 1, 8'(f));
            step(1, 0, 8'(f + 1));
        end
        step(0, 0, 8'h00);
        chk("t7_FrameCnt_sat", {24'd0, FrameCnt}, c_STATS * 255);
        chk("t7_Err", {31'd0, Err}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tdm_demux2_1
`default_nettype wire
